// File: rtl/uart_rx_conditioner_if.sv
// Receive-pin bundle: raw pin in, conditioned line and line status out.
interface uart_rx_conditioner_if;
  logic rxd;
  logic dout;
  logic fall;
  logic idle;
  logic brk;

  modport master (output rxd, input dout, fall, idle, brk);
  modport slave  (input rxd, output dout, fall, idle, brk);
endinterface

// File: rtl/uart_rx_conditioner.sv
// UART rx front end: synchroniser, saturating hysteresis filter, fall/idle/break status.
// Optional break detection is enabled by defining UART_RX_BREAK_DETECT_EN.
module uart_rx_conditioner #(
  parameter int CLK_FREQ    = 27000000,
  parameter int BAUD_RATE   = 115200,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4,
  parameter int IDLE_BITS   = 10,
  parameter int BREAK_BITS  = 11
) (
  input logic clk,
  input logic rst,
  uart_rx_conditioner_if.slave bus
);
  localparam int CYC_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int IDLE_CYC    = IDLE_BITS * CYC_PER_BIT;
  localparam int CNT_W       = $clog2(FILTER_LEN + 1);
  localparam int IDLE_W      = $clog2(IDLE_CYC + 1);
  localparam logic [CNT_W-1:0]  FL       = CNT_W'(FILTER_LEN);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(IDLE_CYC);

  if (SYNC_STAGES < 2 || FILTER_LEN < 1 || IDLE_BITS < 1 || BREAK_BITS < 1) begin : g_bad_cfg
    $error("uart_rx_conditioner: illegal parameter set");
  end

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  logic [CNT_W-1:0]       cnt, cnt_nxt;
  logic                   dout_q, dout_nxt;
  logic                   fall_q;
  logic [IDLE_W-1:0]      idle_cnt, idle_nxt;
  logic                   idle_q;

  assign s = sync[SYNC_STAGES-1];

  always_comb begin
    cnt_nxt = cnt;
    if (s && cnt < FL)
      cnt_nxt = cnt + CNT_W'(1);
    else if (!s && cnt != '0)
      cnt_nxt = cnt - CNT_W'(1);

    // Output only moves when the counter hits a rail; anything in between holds.
    dout_nxt = dout_q;
    if (cnt_nxt == '0)
      dout_nxt = 1'b0;
    else if (cnt_nxt == FL)
      dout_nxt = 1'b1;

    idle_nxt = idle_cnt;
    if (!dout_nxt)
      idle_nxt = '0;
    else if (idle_cnt != IDLE_MAX)
      idle_nxt = idle_cnt + IDLE_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync     <= '1;
      cnt      <= FL;
      dout_q   <= 1'b1;
      fall_q   <= 1'b0;
      idle_cnt <= '0;
      idle_q   <= 1'b0;
    end else begin
      sync     <= {sync[SYNC_STAGES-2:0], bus.rxd};
      cnt      <= cnt_nxt;
      dout_q   <= dout_nxt;
      fall_q   <= dout_q & ~dout_nxt;
      idle_cnt <= idle_nxt;
      idle_q   <= (idle_nxt == IDLE_MAX);
    end
  end

  assign bus.dout = dout_q;
  assign bus.fall = fall_q;
  assign bus.idle = idle_q;

`ifdef UART_RX_BREAK_DETECT_EN
  localparam int BREAK_CYC = BREAK_BITS * CYC_PER_BIT;
  localparam int BRK_W     = $clog2(BREAK_CYC + 1);
  localparam logic [BRK_W-1:0] BRK_MAX = BRK_W'(BREAK_CYC);

  logic [BRK_W-1:0] low_cnt, low_nxt;
  logic             brk_q;

  always_comb begin
    low_nxt = low_cnt;
    if (dout_nxt)
      low_nxt = '0;
    else if (low_cnt != BRK_MAX)
      low_nxt = low_cnt + BRK_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      low_cnt <= '0;
      brk_q   <= 1'b0;
    end else begin
      low_cnt <= low_nxt;
      brk_q   <= (low_nxt == BRK_MAX);
    end
  end

  assign bus.brk = brk_q;
`else
  assign bus.brk = 1'b0;
`endif
endmodule
